// File: rtl/calc_pkg.sv
// Shared constants for the result-to-ASCII formatter: character codes,
// default widths and the encodings of the sequencer state and byte selector.
package calc_pkg;

    localparam int RES_W_DEF  = 33;
    localparam int DIGITS_DEF = 10;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_E     = 8'h45;
    localparam logic [7:0] CH_R     = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONV,
        S_SCAN,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_FREE,
        S_DONE
    } state_t;

    // Which character of the output line is currently being sent.
    typedef enum logic [2:0] {
        B_MINUS,
        B_DIGIT,
        B_CR,
        B_LF,
        B_E,
        B_R1,
        B_R2
    } byte_sel_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock, RES_W steps.
// done is asserted during the final step; bcd holds the result from the
// following cycle until the next start.
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int RES_W  = RES_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [RES_W-1:0]    bin,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int CNT_W = $clog2(RES_W + 1);

    logic [RES_W-1:0]    bin_reg;
    logic [4*DIGITS-1:0] bcd_reg;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [CNT_W-1:0]    cnt_reg;
    logic                run_reg;

    // Add 3 to every nibble that would overflow past 9 after the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        (bcd_reg[gi*4 +: 4] + 4'd3) :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // Load on start, then shift {bcd, bin} left once per cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bin_reg <= '0;
            bcd_reg <= '0;
            cnt_reg <= '0;
            run_reg <= 1'b0;
        end else if (start) begin
            bin_reg <= bin;
            bcd_reg <= '0;
            cnt_reg <= CNT_W'(RES_W);
            run_reg <= 1'b1;
        end else if (run_reg) begin
            {bcd_reg, bin_reg} <= {bcd_adj[4*DIGITS-2:0], bin_reg, 1'b0};
            cnt_reg            <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
                run_reg <= 1'b0;
            end
        end
    end

    assign done = run_reg && (cnt_reg == CNT_W'(1));
    assign bcd  = bcd_reg;

endmodule

// File: rtl/calc_res_ascii_tx.sv
// Formats a signed arithmetic result as a decimal ASCII line ("-123\r\n",
// or "ERR\r\n" on error) and feeds it byte by byte to a UART transmitter.
module calc_res_ascii_tx
    import calc_pkg::*;
#(
    parameter int RES_W   = RES_W_DEF,
    parameter int DIGITS  = DIGITS_DEF,
    parameter int CRLF_EN = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [RES_W-1:0] calc_res,
    input  logic             res_err,
    input  logic             res_done,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic             fmt_busy,
    output logic             fmt_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(DIGITS - 1);

    state_t              state_reg, state_next;
    byte_sel_t           sel_reg, sel_next;
    logic                sign_reg, sign_next;
    logic                err_reg, err_next;
    logic [RES_W-1:0]    mag_reg, mag_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic                tx_start_reg, tx_start_next;
    logic [7:0]          tx_data_reg, tx_data_next;

    logic                bcd_start;
    logic                bcd_done;
    logic [4*DIGITS-1:0] bcd;
    logic [3:0]          cur_nib;
    logic [7:0]          cur_byte;
    logic                is_last;

    bin2bcd_seq #(
        .RES_W  (RES_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .n_rst (n_rst),
        .start (bcd_start),
        .bin   (mag_reg),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    assign cur_nib = bcd[idx_reg*4 +: 4];

    // Character for the current byte selector / digit index.
    always_comb begin
        cur_byte = CH_0;
        case (sel_reg)
            B_MINUS: cur_byte = CH_MINUS;
            B_DIGIT: cur_byte = CH_0 + {4'h0, cur_nib};
            B_CR:    cur_byte = CH_CR;
            B_LF:    cur_byte = CH_LF;
            B_E:     cur_byte = CH_E;
            B_R1:    cur_byte = CH_R;
            B_R2:    cur_byte = CH_R;
            default: cur_byte = CH_0;
        endcase
    end

    // Last byte of the line depends on whether CR LF is appended.
    always_comb begin
        is_last = 1'b0;
        if (CRLF_EN != 0) begin
            is_last = (sel_reg == B_LF);
        end else begin
            is_last = ((sel_reg == B_DIGIT) && (idx_reg == '0)) || (sel_reg == B_R2);
        end
    end

    // Sequencer: next state, latched operands, byte selection and TX handshake.
    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        sign_next     = sign_reg;
        err_next      = err_reg;
        mag_next      = mag_reg;
        idx_next      = idx_reg;
        tx_start_next = 1'b0;
        tx_data_next  = tx_data_reg;
        bcd_start     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (res_done) begin
                    sign_next  = calc_res[RES_W-1];
                    err_next   = res_err;
                    // Held unsigned, so -2^(RES_W-1) maps to 2^(RES_W-1) exactly.
                    mag_next   = calc_res[RES_W-1] ? (~calc_res + RES_W'(1)) : calc_res;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (err_reg) begin
                    sel_next   = B_E;
                    state_next = S_SEND;
                end else begin
                    bcd_start  = 1'b1;
                    state_next = S_CONV;
                end
            end
            S_CONV: begin
                if (bcd_done) begin
                    idx_next   = TOP_IDX;
                    state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                // Stop at the first nonzero digit; digit 0 is always printed.
                if ((cur_nib != 4'd0) || (idx_reg == '0)) begin
                    sel_next   = sign_reg ? B_MINUS : B_DIGIT;
                    state_next = S_SEND;
                end else begin
                    idx_next = idx_reg - IDX_W'(1);
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start_next = 1'b1;
                    tx_data_next  = cur_byte;
                    state_next    = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                state_next = S_WAIT_FREE;
            end
            S_WAIT_FREE: begin
                if (!tx_busy) begin
                    if (is_last) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_SEND;
                        case (sel_reg)
                            B_MINUS: sel_next = B_DIGIT;
                            B_DIGIT: begin
                                if (idx_reg == '0) begin
                                    sel_next = B_CR;
                                end else begin
                                    idx_next = idx_reg - IDX_W'(1);
                                end
                            end
                            B_CR:    sel_next = B_LF;
                            B_E:     sel_next = B_R1;
                            B_R1:    sel_next = B_R2;
                            B_R2:    sel_next = B_CR;
                            default: sel_next = B_LF;
                        endcase
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg    <= S_IDLE;
            sel_reg      <= B_MINUS;
            sign_reg     <= 1'b0;
            err_reg      <= 1'b0;
            mag_reg      <= '0;
            idx_reg      <= '0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            sign_reg     <= sign_next;
            err_reg      <= err_next;
            mag_reg      <= mag_next;
            idx_reg      <= idx_next;
            tx_start_reg <= tx_start_next;
            tx_data_reg  <= tx_data_next;
        end
    end

    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;
    assign fmt_busy = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign fmt_done = (state_reg == S_DONE);

endmodule

// File: tb/tb_calc_res_ascii_tx.sv
// Directed bench for calc_res_ascii_tx with a simple UART TX model that
// stays busy for 10 cycles per byte and records every byte it is handed.
module tb_calc_res_ascii_tx;

    localparam int RES_W = 33;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic [RES_W-1:0] calc_res = '0;
    logic             res_err = 1'b0;
    logic             res_done = 1'b0;
    logic             tx_busy;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             fmt_busy;
    logic             fmt_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    calc_res_ascii_tx #(
        .RES_W   (RES_W),
        .DIGITS  (10),
        .CRLF_EN (1)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .calc_res (calc_res),
        .res_err  (res_err),
        .res_done (res_done),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .fmt_busy (fmt_busy),
        .fmt_done (fmt_done)
    );

    // TX model and capture
    logic       busy_m;
    int         busy_left;
    bit         hold_busy = 1'b0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         acc_cyc = 0;
    logic [7:0] rx_q[$];
    int         rx_cyc_q[$];

    assign tx_busy = busy_m | hold_busy;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy_m    <= 1'b0;
            busy_left <= 0;
        end else begin
            cyc <= cyc + 1;
            if (res_done && !fmt_busy && !fmt_done) acc_cyc <= cyc;
            if (fmt_done) done_cnt <= done_cnt + 1;
            if (tx_start) begin
                rx_q.push_back(tx_data);
                rx_cyc_q.push_back(cyc);
                busy_m    <= 1'b1;
                busy_left <= 9;
            end else if (busy_left > 0) begin
                busy_left <= busy_left - 1;
            end else begin
                busy_m <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One result through the formatter; exp_s is the text before CR LF.
    task automatic run(input string name, input logic [RES_W-1:0] val, input logic err,
                       input string exp_s, input int poke, input int hold_in);
        logic [7:0] exp_q[$];
        logic [7:0] got;
        logic [7:0] held;
        int base, d0, n0, hold;
        bit timeout, stable;
        hold = hold_in;
        for (int i = 0; i < exp_s.len(); i++) exp_q.push_back(exp_s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        base = rx_q.size();
        d0   = done_cnt;
        @(negedge clk);
        calc_res = val; res_err = err; res_done = 1'b1;
        @(negedge clk);
        res_done = 1'b0; calc_res = '0; res_err = 1'b0;
        chk({name, " fmt_busy"}, fmt_busy, 1);
        timeout = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            if (done_cnt != d0) begin
                timeout = 1'b0;
                break;
            end
            if (c == poke) begin
                calc_res = 33'd999; res_done = 1'b1;
                @(negedge clk);
                res_done = 1'b0; calc_res = '0;
            end
            if (hold > 0 && rx_q.size() == base + 1) begin
                hold_busy = 1'b1;
                held   = tx_data;
                n0     = rx_q.size();
                stable = 1'b1;
                repeat (hold) begin
                    @(negedge clk);
                    if (tx_start || tx_data !== held) stable = 1'b0;
                end
                chk({name, " hold stable"}, stable, 1);
                chk({name, " hold no start"}, rx_q.size() - n0, 0);
                hold_busy = 1'b0;
                hold = 0;
            end
            @(negedge clk);
        end
        chk({name, " timeout"}, timeout, 0);
        chk({name, " len"}, rx_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'h00;
            chk($sformatf("%s byte%0d", name, i), got, exp_q[i]);
        end
        repeat (3) @(negedge clk);
        chk({name, " done once"}, done_cnt - d0, 1);
        chk({name, " idle"}, fmt_busy, 0);
        $display("run %-10s bytes=%0d done=%0d", name, rx_q.size() - base, done_cnt - d0);
    endtask

    initial begin
        int b, n_before;
        bit timeout;

        repeat (3) @(negedge clk);
        chk("reset outs", {tx_start, tx_data, fmt_busy, fmt_done}, 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        b = rx_q.size();
        run("18", 33'd18, 1'b0, "18", -1, 0);
        if (rx_cyc_q.size() > b) chk("latency 18", rx_cyc_q[b] - acc_cyc, 45);
        else chk("latency 18", 0, 45);

        run("zero", 33'd0, 1'b0, "0", -1, 0);
        run("neg7", 33'h1_FFFF_FFF9, 1'b0, "-7", -1, 0);
        run("max", 33'h0_FFFF_FFFF, 1'b0, "4294967295", -1, 0);
        run("min", 33'h1_0000_0000, 1'b0, "-4294967296", -1, 0);
        run("err", 33'd5, 1'b1, "ERR", -1, 0);
        run("repulse", 33'd18, 1'b0, "18", 60, 0);
        run("hold", 33'h1_FFFF_FFF9, 1'b0, "-7", -1, 200);

        // Reset while converting.
        @(negedge clk);
        calc_res = 33'd123; res_done = 1'b1;
        @(negedge clk);
        res_done = 1'b0; calc_res = '0;
        repeat (10) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("rst conv outs", {tx_start, tx_data, fmt_busy, fmt_done}, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        // Reset while waiting for the UART to finish a byte.
        b = rx_q.size();
        @(negedge clk);
        calc_res = 33'h0_FFFF_FFFF; res_done = 1'b1;
        @(negedge clk);
        res_done = 1'b0; calc_res = '0;
        timeout = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (rx_q.size() >= b + 2) begin
                timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk("rst wf timeout", timeout, 0);
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("rst wf outs", {tx_start, tx_data, fmt_busy, fmt_done}, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        n_before = rx_q.size();
        repeat (30) @(negedge clk);
        chk("rst no resend", rx_q.size() - n_before, 0);

        run("42", 33'd42, 1'b0, "42", -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
